// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller and its datapath.
// byte_idx() gives the position of a state-matrix element inside a 128-bit block.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } aes_st_e;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  // Byte k of the block holds row k mod 4, column k div 4.
  function automatic logic [3:0] byte_idx(input logic [1:0] row, input logic [1:0] col);
    return {col, row};
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequencer for one AES encryption: owns the state register, round counter and
// both host handshakes, stepping the external round datapath one round per cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a plaintext block
// ST_INIT  | initial AddRoundKey with round key 0
// ST_ROUND | full rounds 1..NR-1 through the datapath
// ST_FINAL | last round, MixColumns bypassed, round key NR
// ST_DONE  | ciphertext presented until the consumer takes it
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  input  logic         rk_ready,
  output logic [127:0] rnd_state,
  output logic         rnd_final,
  input  logic [127:0] rnd_result,
  output logic         busy
);

  generate
    if (NR != AES_NR_128 && NR != AES_NR_192 && NR != AES_NR_256) begin : g_bad_nr
      $error("aes_round_ctrl: NR must be 10, 12 or 14");
    end
  endgenerate

  localparam logic [3:0] NR_L  = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  aes_st_e      st, st_nxt;
  logic [127:0] state_reg, state_nxt;
  logic [3:0]   round, round_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      state_reg <= '0;
      round     <= '0;
    end else begin
      st        <= st_nxt;
      state_reg <= state_nxt;
      round     <= round_nxt;
    end
  end

  // Outputs decode only registered state; inputs only steer the next-state terms.
  always_comb begin
    st_nxt    = st;
    state_nxt = state_reg;
    round_nxt = round;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    rk_idx    = '0;
    rnd_final = 1'b0;
    case (st)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = in_data;
          round_nxt = '0;
          st_nxt    = ST_INIT;
        end
      end
      ST_INIT: begin
        if (rk_ready) begin
          state_nxt = state_reg ^ rk_data;
          round_nxt = 4'd1;
          st_nxt    = ST_ROUND;
        end
      end
      ST_ROUND: begin
        rk_idx = round;
        if (rk_ready) begin
          state_nxt = rnd_result;
          round_nxt = round + 4'd1;
          if (round == NR_M1) st_nxt = ST_FINAL;
        end
      end
      ST_FINAL: begin
        rk_idx    = NR_L;
        rnd_final = 1'b1;
        if (rk_ready) begin
          state_nxt = rnd_result;
          st_nxt    = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_data  = state_reg;
        if (out_ready) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (st != ST_IDLE);
  assign rnd_state = state_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: AES-128 and AES-256 builds driven by a behavioural
// round/key-schedule model, FIPS-197 vectors plus randomized stalls and backpressure.
module tb_aes_round_ctrl;

  logic         clk, rst_n, sel;
  logic         in_valid, out_ready, rk_ready;
  logic [127:0] in_data;

  logic         in_ready10, out_valid10, rnd_final10, busy10;
  logic [127:0] out_data10, rnd_state10, rnd_result10, rk_data10;
  logic [3:0]   rk_idx10;
  logic         in_ready14, out_valid14, rnd_final14, busy14;
  logic [127:0] out_data14, rnd_state14, rnd_result14, rk_data14;
  logic [3:0]   rk_idx14;

  logic         o_in_ready, o_out_valid, o_rnd_final, o_busy;
  logic [127:0] o_out_data, o_rnd_state;
  logic [3:0]   o_rk_idx;

  logic [7:0] sbox_t [0:255];
  logic [7:0] eb10   [0:255];
  logic [7:0] eb14   [0:255];

  int n_cmp, n_bad;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready10),
    .in_data(in_data), .out_valid(out_valid10), .out_ready(out_ready),
    .out_data(out_data10), .rk_idx(rk_idx10), .rk_data(rk_data10), .rk_ready(rk_ready),
    .rnd_state(rnd_state10), .rnd_final(rnd_final10), .rnd_result(rnd_result10),
    .busy(busy10));

  aes_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready14),
    .in_data(in_data), .out_valid(out_valid14), .out_ready(out_ready),
    .out_data(out_data14), .rk_idx(rk_idx14), .rk_data(rk_data14), .rk_ready(rk_ready),
    .rnd_state(rnd_state14), .rnd_final(rnd_final14), .rnd_result(rnd_result14),
    .busy(busy14));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] rev128(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = x[127-8*k -: 8];
    return r;
  endfunction

  // One AES round on a block in controller byte layout (byte k = row k%4, col k/4).
  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] rk,
                                           input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] m [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) b[k] = sbox_t[s[8*k +: 8]];
    for (int rw = 0; rw < 4; rw++)
      for (int c = 0; c < 4; c++) t[rw + 4*c] = b[rw + 4*((c + rw) % 4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (fin) begin
        m[4*c] = a0; m[4*c+1] = a1; m[4*c+2] = a2; m[4*c+3] = a3;
      end else begin
        m[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        m[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        m[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        m[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int k = 0; k < 16; k++) r[8*k +: 8] = m[k] ^ rk[8*k +: 8];
    return r;
  endfunction

  function automatic logic [127:0] get_rk(input logic which, input int idx);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = which ? eb14[16*idx + k] : eb10[16*idx + k];
    return r;
  endfunction

  always_comb begin
    rk_data10 = '0;
    rk_data14 = '0;
    for (int k = 0; k < 16; k++) begin
      rk_data10[8*k +: 8] = eb10[{rk_idx10, 4'(k)}];
      rk_data14[8*k +: 8] = eb14[{rk_idx14, 4'(k)}];
    end
  end

  assign rnd_result10 = aes_rnd(rnd_state10, rk_data10, rnd_final10);
  assign rnd_result14 = aes_rnd(rnd_state14, rk_data14, rnd_final14);

  always_comb begin
    if (sel) begin
      o_in_ready = in_ready14; o_out_valid = out_valid14; o_rnd_final = rnd_final14;
      o_busy = busy14; o_out_data = out_data14; o_rnd_state = rnd_state14; o_rk_idx = rk_idx14;
    end else begin
      o_in_ready = in_ready10; o_out_valid = out_valid10; o_rnd_final = rnd_final10;
      o_busy = busy10; o_out_data = out_data10; o_rnd_state = rnd_state10; o_rk_idx = rk_idx10;
    end
  end

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIPS-197 key expansion; key byte j sits at key[255-8j -: 8].
  task automatic expand_key(input logic which, input logic [255:0] key, input int nk);
    logic [7:0] wb [0:255];
    logic [7:0] t [4];
    logic [7:0] tmp, rcon;
    int nr;
    nr = nk + 6;
    rcon = 8'h01;
    for (int j = 0; j < 256; j++) wb[j] = 8'h00;
    for (int j = 0; j < 4*nk; j++) wb[j] = key[255-8*j -: 8];
    for (int i = nk; i < 4*(nr+1); i++) begin
      for (int b = 0; b < 4; b++) t[b] = wb[4*(i-1) + b];
      if (i % nk == 0) begin
        tmp = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = tmp;
        for (int b = 0; b < 4; b++) t[b] = sbox_t[t[b]];
        t[0] = t[0] ^ rcon;
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        for (int b = 0; b < 4; b++) t[b] = sbox_t[t[b]];
      end
      for (int b = 0; b < 4; b++) wb[4*i + b] = wb[4*(i-nk) + b] ^ t[b];
    end
    for (int j = 0; j < 256; j++) begin
      if (which) eb14[j] = wb[j];
      else       eb10[j] = wb[j];
    end
  endtask

  function automatic int stall_plan(input int mode, input int p, input int nr);
    if (mode == 1) return (p == 0 || p == 5 || p == nr) ? 3 : 0;
    if (mode == 2) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    return 0;
  endfunction

  // Step p of the cipher: p=0 key whitening, 1..nr-1 full rounds, nr final round.
  function automatic logic [127:0] model_step(input logic [127:0] s, input int p, input int nr);
    logic [127:0] rk;
    rk = get_rk(sel, p);
    if (p == 0) return s ^ rk;
    return aes_rnd(s, rk, p == nr);
  endfunction

  task automatic run_block(input logic [127:0] pt, input int stall_mode, input int bp,
                           input int rst_at, output logic [127:0] ct_model,
                           output logic [127:0] ct_dut, output int lat);
    int nr, p, cyc, stalls, left;
    logic [127:0] s;
    nr = sel ? 14 : 10;
    ct_model = '0; ct_dut = '0; lat = -1;
    chk_eq("accept_in_ready", 128'(o_in_ready), 128'(1));
    in_data = pt; in_valid = 1'b1; rk_ready = 1'b0; out_ready = 1'b0;
    tick();
    s = pt; p = 0; cyc = 0; stalls = 0;
    left = stall_plan(stall_mode, 0, nr);
    while (p <= nr) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      chk_eq("run_busy", 128'(o_busy), 128'(1));
      chk_eq("run_out_valid", 128'(o_out_valid), 128'(0));
      chk_eq("run_in_ready", 128'(o_in_ready), 128'(0));
      chk_eq("run_out_data", o_out_data, 128'(0));
      chk_eq("run_rk_idx", 128'(o_rk_idx), 128'(p));
      chk_eq("run_rnd_final", 128'(o_rnd_final), 128'(p == nr));
      chk_eq("run_rnd_state", o_rnd_state, s);
      if (p == rst_at) begin
        in_valid = 1'b0; rk_ready = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_eq("rst_busy", 128'(o_busy), 128'(0));
        chk_eq("rst_out_valid", 128'(o_out_valid), 128'(0));
        chk_eq("rst_rk_idx", 128'(o_rk_idx), 128'(0));
        chk_eq("rst_in_ready", 128'(o_in_ready), 128'(1));
        chk_eq("rst_rnd_final", 128'(o_rnd_final), 128'(0));
        chk_eq("rst_rnd_state", o_rnd_state, 128'(0));
        return;
      end
      if (left > 0) begin
        rk_ready = 1'b0; left--; stalls++;
      end else begin
        rk_ready = 1'b1;
      end
      tick();
      cyc++;
      if (rk_ready) begin
        s = model_step(s, p, nr);
        p++;
        if (p <= nr) left = stall_plan(stall_mode, p, nr);
      end
    end
    rk_ready = 1'($urandom_range(0, 1));
    lat = cyc + 1;
    chk_eq("latency", 128'(lat), 128'(nr + 2 + stalls));
    chk_eq("done_out_valid", 128'(o_out_valid), 128'(1));
    chk_eq("done_busy", 128'(o_busy), 128'(1));
    chk_eq("done_in_ready", 128'(o_in_ready), 128'(0));
    chk_eq("done_rk_idx", 128'(o_rk_idx), 128'(0));
    chk_eq("done_rnd_final", 128'(o_rnd_final), 128'(0));
    chk_eq("done_out_data", o_out_data, s);
    ct_model = s;
    ct_dut = o_out_data;
    for (int i = 0; i < bp; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk_eq("bp_out_valid", 128'(o_out_valid), 128'(1));
      chk_eq("bp_out_data", o_out_data, s);
      chk_eq("bp_in_ready", 128'(o_in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_eq("post_in_ready", 128'(o_in_ready), 128'(1));
    chk_eq("post_busy", 128'(o_busy), 128'(0));
    chk_eq("post_out_valid", 128'(o_out_valid), 128'(0));
    chk_eq("post_out_data", o_out_data, 128'(0));
    chk_eq("post_rnd_state", o_rnd_state, s);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] inv;
    logic [127:0] cm, cd, pt;
    logic [255:0] key;
    int lat, nr;
    n_cmp = 0; n_bad = 0;
    sel = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; rk_ready = 1'b0;
    for (int j = 0; j < 256; j++) begin
      eb10[j] = 8'h00;
      eb14[j] = 8'h00;
    end
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    expand_key(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand_key(1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    tick(); tick();
    rst_n = 1'b1;
    chk_eq("reset_in_ready", 128'({in_ready10, in_ready14}), 128'(2'b11));
    chk_eq("reset_out_valid", 128'({out_valid10, out_valid14}), 128'(0));
    chk_eq("reset_busy", 128'({busy10, busy14}), 128'(0));
    chk_eq("reset_rnd_final", 128'({rnd_final10, rnd_final14}), 128'(0));
    chk_eq("reset_rk_idx", 128'({rk_idx10, rk_idx14}), 128'(0));
    chk_eq("reset_out_data", out_data10 | out_data14, 128'(0));
    chk_eq("reset_rnd_state", rnd_state10 | rnd_state14, 128'(0));

    run_block(rev128(PT), 0, 0, -1, cm, cd, lat);
    chk_eq("c1_model_ct", cm, rev128(CT1));
    chk_eq("c1_dut_ct", cd, rev128(CT1));
    chk_eq("c1_latency", 128'(lat), 128'(12));

    run_block(rev128(PT), 1, 0, -1, cm, cd, lat);
    chk_eq("stall_ct", cd, rev128(CT1));
    chk_eq("stall_latency", 128'(lat), 128'(21));

    run_block(rev128(PT), 0, 10, -1, cm, cd, lat);
    chk_eq("bp_ct", cd, rev128(CT1));

    run_block(rev128(PT), 0, 0, 4, cm, cd, lat);
    run_block(rev128(PT), 0, 0, -1, cm, cd, lat);
    chk_eq("after_rst_ct", cd, rev128(CT1));

    in_valid = 1'b1;
    run_block(rev128(PT), 0, 0, -1, cm, cd, lat);
    run_block(rev128(128'hffeeddccbbaa99887766554433221100), 0, 0, -1, cm, cd, lat);
    chk_eq("b2b_second_ct", cd, cm);

    sel = 1'b1;
    tick();
    run_block(rev128(PT), 0, 0, -1, cm, cd, lat);
    chk_eq("c3_model_ct", cm, rev128(CT3));
    chk_eq("c3_dut_ct", cd, rev128(CT3));
    chk_eq("c3_latency", 128'(lat), 128'(16));

    for (int b = 0; b < 24; b++) begin
      sel = 1'($urandom_range(0, 1));
      tick();
      nr = sel ? 14 : 10;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand_key(sel, key, sel ? 8 : 4);
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_block(pt, 2, int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nr)) : -1, cm, cd, lat);
      if (lat >= 0) chk_eq("rand_ct", cd, cm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencer that drives one AES encryption from plaintext to ciphertext through the combinational round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey, built on the 128-bit-to-4x4 state mapping). It owns the 128-bit state register, the round counter and the round-key index. It also owns the valid/ready handshakes on both sides. It sits between the block-level host interface and the `aes_round` datapath / key schedule, one round per cycle, with stalls allowed from the key schedule.

## Interface
- `NR`, default 10: number of rounds.
  - Legal values are 10, 12 and 14 (AES-128/192/256).
  - Any other value is a static elaboration error.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: plaintext block offered.
- `in_ready` output 1: controller can accept a block.
- `in_data` input 128: plaintext. Byte `[8k+7:8k]` is state byte k, with row = k mod 4 and column = k div 4.
- `out_valid` output 1: ciphertext available.
- `out_ready` input 1: consumer takes the ciphertext.
- `out_data` output 128: ciphertext, same byte layout as `in_data`.
- `rk_idx` output 4: round-key index requested from the key schedule, range 0..NR.
- `rk_data` input 128: round key for `rk_idx`.
- `rk_ready` input 1: `rk_data` is valid for `rk_idx` this cycle.
- `rnd_state` output 128: current state register, fed to the datapath.
- `rnd_final` output 1: datapath must bypass MixColumns this cycle.
- `rnd_result` input 128: combinational datapath result for `rnd_state`, `rk_data` and `rnd_final`.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, INIT, ROUND, FINAL, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: state_reg←`in_data`, round←0, go to INIT.
- **INIT**
  - `rk_idx`=0.
  - If `rk_ready`: state_reg←state_reg XOR `rk_data`, round←1, go to ROUND.
  - Otherwise hold.
- **ROUND**
  - `rk_idx`=round, `rnd_final`=0.
  - If `rk_ready`: state_reg←`rnd_result`, round←round+1.
  - When the round just completed equals NR−1, go to FINAL.
  - Otherwise hold: state_reg and round are unchanged.
- **FINAL**
  - `rk_idx`=NR, `rnd_final`=1.
  - If `rk_ready`: state_reg←`rnd_result`, go to DONE.
- **DONE**
  - `out_valid`=1, `out_data`=state_reg, held stable until `out_ready`.
  - On `out_ready`: go to IDLE.
  - No acceptance in DONE: `in_ready`=0.
- Round counter: 4 bits, never exceeds NR, no wrap. `rk_idx` is 0 outside INIT/ROUND/FINAL.
- `in_valid` outside IDLE is ignored. The held block is not affected.
- `rnd_state` always equals state_reg. `out_data` is 0 when `out_valid`=0.

## Timing
- Reset (`rst_n`=0 at an edge):
  - FSM goes to IDLE; state_reg=0, round=0.
  - Next-cycle outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `rnd_final`=0, `rk_idx`=0, `out_data`=0.
  - Handshakes are not evaluated in the reset cycle.
- Reset mid-operation (any state) discards the block. No `out_valid` pulse follows.
- Latency with `rk_ready` held high:
  - Accept edge E0, INIT during cycle 1, ROUND during cycles 2..NR, FINAL during cycle NR+1.
  - `out_valid` rises in cycle NR+2: 12 cycles for NR=10, 14 for NR=12, 16 for NR=14.
- Each cycle with `rk_ready`=0 in INIT/ROUND/FINAL adds exactly one cycle.
- Throughput: one block per NR+3 cycles minimum, including the IDLE acceptance cycle after DONE.
- `out_valid`∧`out_ready` in DONE with `in_valid` high: the block is accepted in the next (IDLE) cycle, not the same cycle.
- All outputs are functions of registered state only. There is no combinational path from `in_valid`/`out_ready`/`rk_ready` to any output.

## Structure
- Shared package `aes_pkg` holds:
  - the FSM state enum (`ST_IDLE`..`ST_DONE`);
  - `AES_NR_128/192/256` = 10/12/14;
  - the byte-index helper `byte_idx(row,col)` = 4·col+row, matching the state-matrix layout.
- No sub-module. FSM, counter and state register stay in one module.
- `aes_round` (datapath) and the key schedule remain external and are instantiated by the top level.

## Test plan
- **FIPS-197 C.1 vector.** Key `000102…0f`, `in_data`=`00112233445566778899aabbccddeeff`, `rk_ready`=1, bench datapath plus key schedule model.
  - `out_valid` rises exactly 12 cycles after accept.
  - `out_data`=`69c4e0d86a7b0430d8cdb78070b4c55a`.
- **Key stalls.** Same vector with `rk_ready`=0 for 3 cycles in INIT, round 5 and FINAL.
  - Same ciphertext, latency 21.
  - `rk_idx` and state_reg held during each stall.
- **Output backpressure.** `out_ready`=0 for 10 cycles after `out_valid`.
  - `out_data` stable, `in_ready`=0 throughout.
  - After `out_ready`=1, `in_ready`=1 next cycle.
- **Reset mid-operation.** `rst_n`=0 for 1 cycle while in round 4.
  - Next cycle: IDLE, `busy`=0, `out_valid`=0, `rk_idx`=0.
  - A fresh block afterwards completes correctly.
- **NR=14 build.** FIPS-197 C.3 key `000102…1f`, same plaintext.
  - `out_data`=`8ea2b7ca516745bfeafc49904b496089` at 16 cycles.
  - `rnd_final`=1 only while `rk_idx`=14.
- **Back-to-back blocks.** Two blocks with `in_valid` held high.
  - The second block is accepted only in the IDLE cycle following the first `out_ready`.
  - `in_valid` during busy cycles leaves state_reg unchanged.
